// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared definitions for the BCD sum accumulator.
//   state_t     - accumulator FSM states (IDLE, ADD, ADJ, DONE)
//   BCD_MAX     - largest legal BCD digit value
//   SEG_BLANK   - all segments off (active-high, order g..a)
//   SEG_DIGITS  - active-high segment patterns for digits 0..9
//   seg_pattern - digit-to-pattern lookup; codes 10..15 return SEG_BLANK
package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    ADJ  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BCD_MAX = 9;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Index 9 is the leftmost element of the packed array.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    if (digit > 4'(BCD_MAX)) begin
      seg_pattern = SEG_BLANK;
    end else begin
      seg_pattern = SEG_DIGITS[digit];
    end
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD digit to seven-segment decoder.
//   digit - 4-bit BCD digit (10..15 display blank)
//   seg   - 7-bit segment pattern, order g..a, active-high
module bcd_to_7seg
  import sum_acc_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_pattern(digit);
  end

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates 0..15 operands into a two-digit BCD running
// total (0..99) and drives two seven-segment displays.
//
// Parameters
//   HEX_ACTIVE_LOW - 1: hex outputs active-low (DE0-CV), 0: active-high
//   OPERAND_W      - width of load_w
// Build option
//   SUM_SATURATE_EN - defined: tens overflow clamps the total to 99;
//                     undefined: total wraps modulo 100. ovf is set either way.
// Ports
//   clk        - system clock, rising edge
//   rst        - synchronous reset, active-low
//   load_w     - operand to add (0..15)
//   load_valid - one-cycle strobe qualifying load_w
//   clear      - synchronous clear of total and flags, aborts any operation
//   busy       - high in ADD, ADJ and DONE
//   done       - one-cycle pulse in DONE, the cycle after the total updates
//   sum_tens   - BCD tens digit of the running total
//   sum_ones   - BCD ones digit of the running total
//   ovf        - sticky: the total passed 99
//   dropped    - sticky: load_valid arrived while busy
//   hex1, hex0 - segment patterns (g..a) for sum_tens / sum_ones
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter bit HEX_ACTIVE_LOW = 1'b1,
  parameter int OPERAND_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] load_w,
  input  logic                 load_valid,
  input  logic                 clear,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           sum_tens,
  output logic [3:0]           sum_ones,
  output logic                 ovf,
  output logic                 dropped,
  output logic [6:0]           hex1,
  output logic [6:0]           hex0
);

  state_t                 state_q;
  state_t                 state_d;
  logic [OPERAND_W-1:0]   operand;
  logic [4:0]             ones_tmp;
  logic [1:0]             carry;
  logic [8:0]             folded;
  logic [6:0]             seg_tens;
  logic [6:0]             seg_ones;

  // Folds the pending carry into the tens digit. Result is
  // {overflow, tens, ones}; overflow either wraps or clamps to 99.
  function automatic logic [8:0] fold_total(input logic [3:0] tens,
                                            input logic [1:0] cy,
                                            input logic [3:0] ones);
    logic [4:0] t;
    t = {1'b0, tens} + {3'b000, cy};
    if (t > 5'(BCD_MAX)) begin
`ifdef SUM_SATURATE_EN
      fold_total = {1'b1, 4'(BCD_MAX), 4'(BCD_MAX)};
`else
      fold_total = {1'b1, 4'(t - 5'd10), ones};
`endif
    end else begin
      fold_total = {1'b0, t[3:0], ones};
    end
  endfunction

  always_comb begin
    folded = fold_total(sum_tens, carry, ones_tmp[3:0]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (load_valid) state_d = ADD;
        ADD:  state_d = ADJ;
        ADJ:  if (ones_tmp <= 5'(BCD_MAX)) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath: operand capture, ones add, one decimal correction per ADJ cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      operand  <= '0;
      ones_tmp <= '0;
      carry    <= '0;
      sum_tens <= '0;
      sum_ones <= '0;
      ovf      <= 1'b0;
      dropped  <= 1'b0;
    end else if (clear) begin
      carry    <= '0;
      sum_tens <= '0;
      sum_ones <= '0;
      ovf      <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      // Any strobe outside IDLE, including the DONE->IDLE cycle, is lost.
      if (load_valid && state_q != IDLE) begin
        dropped <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            operand <= load_w;
            carry   <= '0;
          end
        end
        ADD: begin
          ones_tmp <= {1'b0, sum_ones} + 5'(operand);
        end
        ADJ: begin
          if (ones_tmp > 5'(BCD_MAX)) begin
            ones_tmp <= ones_tmp - 5'd10;
            carry    <= carry + 2'd1;
          end else begin
            sum_tens <= folded[7:4];
            sum_ones <= folded[3:0];
            if (folded[8]) begin
              ovf <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  bcd_to_7seg u_seg_tens (
    .digit (sum_tens),
    .seg   (seg_tens)
  );

  bcd_to_7seg u_seg_ones (
    .digit (sum_ones),
    .seg   (seg_ones)
  );

  always_comb begin
    hex1 = HEX_ACTIVE_LOW ? ~seg_tens : seg_tens;
    hex0 = HEX_ACTIVE_LOW ? ~seg_ones : seg_ones;
  end

endmodule
